// File: rtl/divisao.sv
// divisao: sequential restoring divider for DIV / DIVU.
// HI (resultHigh) = remainder, LO (resultLow) = quotient.
// Signed (truncate toward zero) by default.
// One iteration per falling clock edge.
// A start pulse in IDLE launches WIDTH iterations plus one sign-fix edge.
// Optional feature macro: DIVU_SUPPORT_EN adds the Unsigned input for DIVU.
module divisao #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             DivStart,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef DIVU_SUPPORT_EN
    input  logic             Unsigned,
`endif
    output logic [WIDTH-1:0] resultHigh,
    output logic [WIDTH-1:0] resultLow,
    output logic             DivOut,
    output logic             DivZero,
    output logic             DivBusy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             sign_q;
    logic             sign_r;

    logic             unsigned_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;

`ifdef DIVU_SUPPORT_EN
    assign unsigned_op = Unsigned;
`else
    assign unsigned_op = 1'b0;
`endif

    // Operand magnitudes and one restoring-division step.
    // Trial subtraction uses WIDTH+1 bits so the shifted remainder never overflows.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        a_mag       = A;
        b_mag       = B;
        rem_shifted = {rem, quo[WIDTH-1]};
        trial       = rem_shifted - {1'b0, divisor};
        trial_ok    = (rem_shifted >= {1'b0, divisor});
        rem_next    = rem_shifted[WIDTH-1:0];

        // |0x80000000| stays 0x80000000, read as unsigned in the magnitude registers.
        if (!unsigned_op && A[WIDTH-1]) a_mag = -A;
        if (!unsigned_op && B[WIDTH-1]) b_mag = -B;

        if (trial_ok) rem_next = trial[WIDTH-1:0];
    end

    // Control FSM and datapath.
    // All state changes on the falling edge; Reset is synchronous.
    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state      <= IDLE;
            count      <= '0;
            divisor    <= '0;
            rem        <= '0;
            quo        <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            resultHigh <= '0;
            resultLow  <= '0;
            DivOut     <= 1'b0;
            DivZero    <= 1'b0;
            DivBusy    <= 1'b0;
        end else begin
            DivOut  <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (DivStart) begin
                        if (B == '0) begin
                            // Divide-by-zero: flag for one cycle, results untouched.
                            DivOut  <= 1'b1;
                            DivZero <= 1'b1;
                        end else begin
                            divisor <= b_mag;
                            quo     <= a_mag;
                            rem     <= '0;
                            count   <= '0;
                            sign_q  <= !unsigned_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                            sign_r  <= !unsigned_op && A[WIDTH-1];
                            DivBusy <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    quo   <= {quo[WIDTH-2:0], trial_ok};
                    count <= count + 1'b1;
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    // Overflow case 0x80000000 / -1 naturally yields 0x80000000.
                    resultLow  <= sign_q ? -quo : quo;
                    resultHigh <= sign_r ? -rem : rem;
                    DivOut     <= 1'b1;
                    DivBusy    <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divisao.sv
// tb_divisao: directed test of divisao.
// An arithmetic reference model predicts every output on every cycle.
// Literal checks pin the model against hand-computed values.
// Optional feature macro: DIVU_SUPPORT_EN enables the DIVU vectors.
module tb_divisao;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             DivStart = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
`ifdef DIVU_SUPPORT_EN
    logic             Unsigned = 1'b0;
`endif
    logic [WIDTH-1:0] resultHigh;
    logic [WIDTH-1:0] resultLow;
    logic             DivOut;
    logic             DivZero;
    logic             DivBusy;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    divisao #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .DivStart   (DivStart),
        .A          (A),
        .B          (B),
`ifdef DIVU_SUPPORT_EN
        .Unsigned   (Unsigned),
`endif
        .resultHigh (resultHigh),
        .resultLow  (resultLow),
        .DivOut     (DivOut),
        .DivZero    (DivZero),
        .DivBusy    (DivBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic             m_out = 1'b0, m_zero = 1'b0, m_busy = 1'b0;
    int               m_left = 0;

    // Quotient and remainder from plain arithmetic.
    // Signed operands are widened to 64 bits, so 0x80000000 / -1 wraps back to 0x80000000.
    function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic u, output logic [WIDTH-1:0] q,
                                    output logic [WIDTH-1:0] r);
        longint sa, sb;
        if (u) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = WIDTH'(sa / sb);
            r  = WIDTH'(sa % sb);
        end
    endfunction

    // Model: a busy window of WIDTH+1 edges, then a done pulse carrying the prepared results.
    always @(negedge clk) begin
        logic u_now;
`ifdef DIVU_SUPPORT_EN
        u_now = Unsigned;
`else
        u_now = 1'b0;
`endif
        m_out  = 1'b0;
        m_zero = 1'b0;
        if (Reset) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_out = 1'b1; m_hi = p_hi; m_lo = p_lo;
            end
        end else if (DivStart) begin
            if (B == '0) begin
                m_out = 1'b1; m_zero = 1'b1;
            end else begin
                ref_div(A, B, u_now, p_lo, p_hi);
                m_left = LAT;
                m_busy = 1'b1;
            end
        end
    end

    // Compare every output against the model on the rising edge, mid-cycle.
    always @(posedge clk) begin
        if (cmp_en) begin
            check("cmp_hi",   resultHigh, m_hi);
            check("cmp_lo",   resultLow,  m_lo);
            check("cmp_out",  WIDTH'(DivOut),  WIDTH'(m_out));
            check("cmp_zero", WIDTH'(DivZero), WIDTH'(m_zero));
            check("cmp_busy", WIDTH'(DivBusy), WIDTH'(m_busy));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_only(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic u);
        @(posedge clk); #1;
        A = a; B = b; DivStart = 1'b1;
`ifdef DIVU_SUPPORT_EN
        Unsigned = u;
`else
        if (u) $display("note: unsigned request ignored in signed-only build");
`endif
        @(posedge clk); #1;
        DivStart = 1'b0;
    endtask

    // Issue one start, then wait (bounded) for DivOut, counting busy cycles on the way.
    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic u, output int busy_cycles);
        logic seen;
        seen = 1'b0;
        busy_cycles = 0;
        @(posedge clk); #1;
        A = a; B = b; DivStart = 1'b1;
`ifdef DIVU_SUPPORT_EN
        Unsigned = u;
`else
        if (u) $display("note: unsigned request ignored in signed-only build");
`endif
        for (int i = 0; i < 3 * LAT && !seen; i++) begin
            @(posedge clk);
            if (DivBusy) busy_cycles++;
            if (DivOut) seen = 1'b1;
            #1 DivStart = 1'b0;
        end
        if (!seen) $display("FAIL %s_timeout: DivOut never seen", name);
        n_checks++;
        if (seen) n_pass++;
    endtask

    initial begin
        int bc, outs;

        // ---- reset ----
        repeat (3) @(posedge clk);
        check("rst_hi",   resultHigh, 32'h0);
        check("rst_lo",   resultLow,  32'h0);
        check("rst_busy", WIDTH'(DivBusy), 32'h0);
        check("rst_out",  WIDTH'(DivOut),  32'h0);
        #1 Reset = 1'b0;
        cmp_en = 1'b1;

        // ---- 1: 100 / 7 ----
        run_op("t1", 32'd100, 32'd7, 1'b0, bc);
        check("t1_busy_cycles", bc, 33);
        check("t1_lo", resultLow,  32'd14);
        check("t1_hi", resultHigh, 32'd2);

        // ---- 3: divide by zero keeps prior results ----
        run_op("t3", 32'd5, 32'd0, 1'b0, bc);
        check("t3_busy_cycles", bc, 0);
        check("t3_zero", WIDTH'(DivZero), 32'h1);
        check("t3_lo", resultLow,  32'd14);
        check("t3_hi", resultHigh, 32'd2);

        // ---- 2: signed truncation ----
        run_op("t2a", 32'hFFFF_FFF9, 32'd2, 1'b0, bc);
        check("t2a_lo", resultLow,  32'hFFFF_FFFD);
        check("t2a_hi", resultHigh, 32'hFFFF_FFFF);
        run_op("t2b", 32'd7, 32'hFFFF_FFFE, 1'b0, bc);
        check("t2b_lo", resultLow,  32'hFFFF_FFFD);
        check("t2b_hi", resultHigh, 32'd1);

        // ---- 4: most-negative dividend ----
        run_op("t4a", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc);
        check("t4a_lo", resultLow,  32'h8000_0000);
        check("t4a_hi", resultHigh, 32'h0);
        run_op("t4b", 32'h8000_0000, 32'd1, 1'b0, bc);
        check("t4b_lo", resultLow,  32'h8000_0000);
        check("t4b_hi", resultHigh, 32'h0);

        // ---- 5a: reset mid-run aborts, no DivOut afterwards ----
        start_only(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk);
        check("t5_abort_hi",   resultHigh, 32'h0);
        check("t5_abort_lo",   resultLow,  32'h0);
        check("t5_abort_busy", WIDTH'(DivBusy), 32'h0);
        #1 Reset = 1'b0;
        outs = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            if (DivOut) outs++;
        end
        check("t5_no_done", outs, 0);

        // ---- 5b: 9 / 3 with a second start mid-run ignored ----
        start_only(32'd9, 32'd3, 1'b0);
        repeat (5) @(posedge clk);
        #1 A = 32'd50; B = 32'd5; DivStart = 1'b1;
        @(posedge clk); #1 DivStart = 1'b0;
        outs = 0;
        for (int i = 0; i < 2 * LAT && outs == 0; i++) begin
            @(posedge clk);
            if (DivOut) outs++;
        end
        check("t5_done_seen", outs, 1);
        check("t5_lo", resultLow,  32'd3);
        check("t5_hi", resultHigh, 32'd0);

        // ---- start on the completing edge is ignored ----
        start_only(32'd12, 32'd5, 1'b0);
        repeat (32) @(posedge clk);
        #1 A = 32'd20; B = 32'd4; DivStart = 1'b1;
        @(posedge clk);
        check("fix_done", WIDTH'(DivOut), 32'h1);
        #1 DivStart = 1'b0;
        repeat (3) @(posedge clk);
        check("fix_ignored_busy", WIDTH'(DivBusy), 32'h0);
        check("fix_lo", resultLow,  32'd2);
        check("fix_hi", resultHigh, 32'd2);

`ifdef DIVU_SUPPORT_EN
        // ---- 6: unsigned vs signed on the same operands ----
        run_op("t6u", 32'hFFFF_FFFF, 32'd2, 1'b1, bc);
        check("t6u_lo", resultLow,  32'h7FFF_FFFF);
        check("t6u_hi", resultHigh, 32'd1);
        run_op("t6s", 32'hFFFF_FFFF, 32'd2, 1'b0, bc);
        check("t6s_lo", resultLow,  32'h0);
        check("t6s_hi", resultHigh, 32'hFFFF_FFFF);
`endif

        repeat (3) @(posedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
